// File: rtl/multiplexer_pipe_n.sv
// Registered N-input operand selector with valid/ready handshake, flush and illegal-select flag.
// Optional saturating illegal-select counter on ERR_COUNT when MUX_SEL_ERR_CNT_EN is defined.
module multiplexer_pipe_n #(
    parameter int unsigned       WIDTH       = 32,
    parameter int unsigned       NUM_IN      = 5,
    parameter int unsigned       SEL_W       = 3,
    parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0,
    parameter int unsigned       ERR_CNT_W   = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NUM_IN*WIDTH-1:0] i_in_bus,
    input  logic [SEL_W-1:0]        i_select,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic                    i_flush,
    output logic [WIDTH-1:0]        o_out,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic                    o_sel_err
`ifdef MUX_SEL_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]    o_err_count
`endif
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_sel_err;

    logic [WIDTH-1:0] w_sel_data;
    logic             w_illegal;
    logic             w_accept;

    // Codes NUM_IN .. 2**SEL_W-1 fall through to DEFAULT_VAL, so the result is never X.
    always_comb begin
        w_sel_data = DEFAULT_VAL;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (32'(i_select) == k) begin
                w_sel_data = i_in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_illegal   = (32'(i_select) >= NUM_IN);
    assign o_in_ready  = !i_flush && ((r_state == StEmpty) || i_out_ready);
    assign w_accept    = i_in_valid && o_in_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StEmpty;
            r_out     <= '0;
            r_sel_err <= 1'b0;
        end else if (i_flush) begin
            r_state   <= StEmpty;
            r_sel_err <= 1'b0;
        end else if (w_accept) begin
            r_state   <= StFull;
            r_out     <= w_sel_data;
            r_sel_err <= w_illegal;
        end else if ((r_state == StFull) && i_out_ready) begin
            r_state   <= StEmpty;
        end
    end

    assign o_out       = r_out;
    assign o_out_valid = (r_state == StFull);
    assign o_sel_err   = r_sel_err;

`ifdef MUX_SEL_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_count;

    // Not cleared by flush; w_accept already excludes flush cycles.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err_count <= '0;
        end else if (w_accept && w_illegal && (r_err_count != {ERR_CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign o_err_count = r_err_count;
`endif

endmodule

// File: tb/tb_multiplexer_pipe_n.sv
// Scoreboard bench for multiplexer_pipe_n (WIDTH=32, NUM_IN=5, SEL_W=3, DEFAULT_VAL=0).
// Checks ERR_COUNT as well when MUX_SEL_ERR_CNT_EN is defined.
module tb_multiplexer_pipe_n;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [159:0] in_bus;
    logic [2:0]   sel = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         flush = 1'b0;
    logic [31:0]  out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         sel_err;
`ifdef MUX_SEL_ERR_CNT_EN
    logic [7:0]   err_count;
    logic [7:0]   m_cnt;
`endif

    // Expected response for the vector currently driven (hand-computed by the stimulus).
    logic [31:0]  exp_d = '0;
    logic         exp_e = 1'b0;

    exp_t         q[$];
    logic [31:0]  m_out;
    logic         m_err;
    logic         started = 1'b0;
    int           n_checks = 0;
    int           n_errors = 0;
    int           n_xfer = 0;

    multiplexer_pipe_n #(
        .WIDTH      (32),
        .NUM_IN     (5),
        .SEL_W      (3),
        .DEFAULT_VAL(32'h0),
        .ERR_CNT_W  (8)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_in_bus   (in_bus),
        .i_select   (sel),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_flush    (flush),
        .o_out      (out),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_sel_err  (sel_err)
`ifdef MUX_SEL_ERR_CNT_EN
        ,
        .o_err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    assign in_bus = {32'h1000_0004, 32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model of the handshake; data values come from the stimulus.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_out   <= '0;
            m_err   <= 1'b0;
            started <= 1'b1;
`ifdef MUX_SEL_ERR_CNT_EN
            m_cnt   <= '0;
`endif
        end else if (flush) begin
            if (q.size() != 0) void'(q.pop_front());
            m_err <= 1'b0;
        end else if (q.size() == 0 || out_ready) begin
            if (q.size() != 0) void'(q.pop_front());
            if (in_valid) begin
                q.push_back('{d: exp_d, e: exp_e});
                m_out <= exp_d;
                m_err <= exp_e;
`ifdef MUX_SEL_ERR_CNT_EN
                if (exp_e && m_cnt != 8'hFF) m_cnt <= m_cnt + 8'd1;
`endif
            end
        end
    end

    // Monitor: compares DUT outputs against the scoreboard head away from the clock edge.
    always @(negedge clk) begin
        if (started) begin
            check("in_ready", 32'(in_ready), 32'(!flush && (q.size() == 0 || out_ready)));
            check("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check("out_data", out, q[0].d);
                check("sel_err", 32'(sel_err), 32'(q[0].e));
                if (out_ready && !flush && !rst) n_xfer++;
            end else begin
                check("out_hold", out, m_out);
                check("sel_err_idle", 32'(sel_err), 32'(m_err));
            end
`ifdef MUX_SEL_ERR_CNT_EN
            check("err_count", 32'(err_count), 32'(m_cnt));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] d,
                         input logic e, input logic ordy, input logic fl);
        in_valid  = v;
        sel       = s;
        exp_d     = d;
        exp_e     = e;
        out_ready = ordy;
        flush     = fl;
    endtask

    logic [2:0]  st_sel [8] = '{3'd0, 3'd4, 3'd2, 3'd1, 3'd3, 3'd7, 3'd4, 3'd0};
    logic [31:0] st_exp [8] = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0002, 32'h1000_0001,
                                32'h1000_0003, 32'h0000_0000, 32'h1000_0004, 32'h1000_0000};
    logic        st_err [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int          exp_xfer;

    initial begin
        // 1: reset
        #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        // 2: select 3
        drive(1, 3'd3, 32'h1000_0003, 0, 1, 0);
        tick();
        drive(0, 3'd0, 32'h0, 0, 1, 0);
        tick();
        // 3: stall three cycles with changing select, then release with a same-edge accept
        drive(1, 3'd1, 32'h1000_0001, 0, 0, 0);
        tick();
        drive(1, 3'd2, 32'h1000_0002, 0, 0, 0);
        tick();
        drive(1, 3'd4, 32'h1000_0004, 0, 0, 0);
        tick();
        drive(1, 3'd0, 32'h1000_0000, 0, 0, 0);
        tick();
        drive(1, 3'd2, 32'h1000_0002, 0, 1, 0);
        tick();
        drive(0, 3'd0, 32'h0, 0, 1, 0);
        tick();
        // 4: illegal selects produce DEFAULT_VAL and the flag
        drive(1, 3'd6, 32'h0, 1, 1, 0);
        tick();
        drive(1, 3'd7, 32'h0, 1, 1, 0);
        tick();
        drive(1, 3'd5, 32'h0, 1, 1, 0);
        tick();
        drive(0, 3'd0, 32'h0, 0, 1, 0);
        tick();
`ifdef MUX_SEL_ERR_CNT_EN
        for (int i = 0; i < 300; i++) begin
            drive(1, 3'd6, 32'h0, 1, 1, 0);
            tick();
        end
        drive(0, 3'd0, 32'h0, 0, 1, 0);
        tick();
`endif
        // 5: flush while FULL with an illegal item in flight and IN_VALID high
        drive(1, 3'd5, 32'h0, 1, 0, 0);
        tick();
        drive(1, 3'd6, 32'h0, 1, 0, 1);
        tick();
        drive(0, 3'd0, 32'h0, 0, 1, 0);
        tick();
        tick();
        // 6: reset wins over a valid input, then an 8-item stream
        drive(1, 3'd2, 32'h1000_0002, 0, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 3'd0, 32'h0, 0, 1, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1, st_sel[i], st_exp[i], st_err[i], 1, 0);
            tick();
        end
        drive(0, 3'd0, 32'h0, 0, 1, 0);
        tick();
        tick();

        exp_xfer = 14;
`ifdef MUX_SEL_ERR_CNT_EN
        exp_xfer += 300;
`endif
        check("xfer_count", 32'(n_xfer), 32'(exp_xfer));
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete by %0t", $time);
        $fatal(1);
    end

endmodule
